// File: rtl/ika9958_pkg.sv
// Shared types and default timing constants for the IKA9958 clock/reset front end.
// No datapath; constants only.
// No flow control.
package ika9958_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        NOCLK  = 2'd2
    } clkgen_state_t;

    localparam int LOCK_EDGES_DEF  = 4;
    localparam int NOCLK_TICKS_DEF = 16;
    localparam int RST_HOLD_DEF    = 8;

    // Counter width able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ika9958_sync2.sv
// Two-flop synchronizer, resets to 1 (idle level of an active-low clock).
// Latency: 2 CLK cycles, runs on every edge regardless of tick enable.
// No flow control.
module ika9958_sync2 (
    input  logic CLK,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ika9958_clkgen.sv
// VDP clock divider with slave phase lock and core reset release; IKA9958_CLKGEN_MISCNT_EN adds a realign counter.
// Latency: phase outputs are flops (0 added cycles); DLCLK input sees 2 sync cycles + up to 1 tick.
// No flow control; all state advances only on i_XTAL_NCEN ticks.
module ika9958_clkgen
    import ika9958_pkg::*;
#(
    parameter bit CM          = 1'b1,
    parameter int LOCK_EDGES  = LOCK_EDGES_DEF,
    parameter int NOCLK_TICKS = NOCLK_TICKS_DEF,
    parameter int RST_HOLD    = RST_HOLD_DEF
) (
    input  logic       i_XTAL1,
    input  logic       i_RST,
    input  logic       i_XTAL_NCEN,
    input  logic       i_DLCLK_n,
    output logic       o_DHCLK_n,
    output logic       o_DLCLK_n,
    output logic [1:0] o_PHASE,
    output logic       o_LOCKED,
    output logic       o_IRST,
    output logic [7:0] o_MISCNT
);

    localparam int CW = cnt_w(LOCK_EDGES);
    localparam int TW = cnt_w(NOCLK_TICKS);
    localparam int HW = cnt_w(RST_HOLD);
    localparam logic [CW-1:0] CNT_LAST  = CW'(LOCK_EDGES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(NOCLK_TICKS);
    localparam logic [TW-1:0] TO_LAST   = TW'(NOCLK_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    logic          tick, dl_sync, dl_prev, fall, aligned, timeout;
    logic [1:0]    ph;
    clkgen_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [TW-1:0] to_cnt;
    logic [HW-1:0] hold;
    logic          irst, mlock;

    ika9958_sync2 u_sync (
        .CLK (i_XTAL1),
        .rst (i_RST),
        .d   (i_DLCLK_n),
        .q   (dl_sync)
    );

    assign tick    = i_XTAL_NCEN;
    // Master mode never sees an edge, so divider and FSM simply free-run/hold.
    assign fall    = CM && tick && dl_prev && !dl_sync;
    assign aligned = (ph == 2'd3);
    assign timeout = CM && tick && !fall && (to_cnt == TO_LAST);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (fall) begin
            case (state)
                SEARCH: begin
                    if (!aligned)             cnt_nx = '0;
                    else if (cnt == CNT_LAST) begin
                        state_nx = LOCKED;
                        cnt_nx   = '0;
                    end else                  cnt_nx = cnt + 1'b1;
                end
                LOCKED: begin
                    if (!aligned) begin
                        state_nx = SEARCH;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = SEARCH;
                    cnt_nx   = '0;
                end
            endcase
        end else if (timeout) begin
            state_nx = NOCLK;
        end
    end

    always_ff @(posedge i_XTAL1 or posedge i_RST) begin
        if (i_RST) begin
            ph      <= 2'b11;
            dl_prev <= 1'b1;
            state   <= SEARCH;
            cnt     <= '0;
            to_cnt  <= '0;
            hold    <= '0;
            irst    <= 1'b1;
            mlock   <= 1'b0;
        end else if (tick) begin
            dl_prev <= dl_sync;
            ph      <= fall ? 2'd0 : ph + 2'd1;
            state   <= state_nx;
            cnt     <= cnt_nx;
            mlock   <= 1'b1;
            if (fall)                 to_cnt <= '0;
            else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            // Reset release is one-way; only i_RST brings o_IRST back.
            if (irst) begin
                if (!o_LOCKED)              hold <= '0;
                else if (hold == HOLD_LAST) irst <= 1'b0;
                else                        hold <= hold + 1'b1;
            end
        end
    end

`ifdef IKA9958_CLKGEN_MISCNT_EN
    logic       realign_lock;
    logic [7:0] miscnt;

    assign realign_lock = fall && (state == LOCKED) && !aligned;

    always_ff @(posedge i_XTAL1 or posedge i_RST) begin
        if (i_RST)                                miscnt <= 8'h00;
        else if (realign_lock && miscnt != 8'hFF) miscnt <= miscnt + 8'h01;
    end

    assign o_MISCNT = miscnt;
`else
    assign o_MISCNT = 8'h00;
`endif

    assign o_DHCLK_n = ph[0];
    assign o_DLCLK_n = ph[1];
    assign o_PHASE   = ph;
    assign o_LOCKED  = CM ? (state == LOCKED) : mlock;
    assign o_IRST    = irst;

endmodule

// File: tb/tb_ika9958_clkgen.sv
// Bench for ika9958_clkgen: master and slave instances against a tick-level reference model.
module tb_ika9958_clkgen;

    localparam int LOCK_EDGES  = 4;
    localparam int NOCLK_TICKS = 16;
    localparam int RST_HOLD    = 8;
    localparam int S_SEARCH = 0, S_LOCK = 1, S_NOCLK = 2;
    localparam logic [13:0] RST_EXP = {1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h00};
`ifdef IKA9958_CLKGEN_MISCNT_EN
    localparam logic [7:0] MIS_EXP = 8'd1;
`else
    localparam logic [7:0] MIS_EXP = 8'd0;
`endif

    logic clk = 1'b0, rst = 1'b1, ncen = 1'b0, dl = 1'b1;
    always #5 clk = ~clk;

    logic       dh0, dlo0, lk0, ir0, dh1, dlo1, lk1, ir1;
    logic [1:0] ph0, ph1;
    logic [7:0] mc0, mc1;
    logic [13:0] obs0, obs1;
    assign obs0 = {dlo0, dh0, ph0, lk0, ir0, mc0};
    assign obs1 = {dlo1, dh1, ph1, lk1, ir1, mc1};

    ika9958_clkgen #(.CM(1'b0)) u0 (
        .i_XTAL1(clk), .i_RST(rst), .i_XTAL_NCEN(ncen), .i_DLCLK_n(dl),
        .o_DHCLK_n(dh0), .o_DLCLK_n(dlo0), .o_PHASE(ph0), .o_LOCKED(lk0),
        .o_IRST(ir0), .o_MISCNT(mc0)
    );

    ika9958_clkgen #(.CM(1'b1)) u1 (
        .i_XTAL1(clk), .i_RST(rst), .i_XTAL_NCEN(ncen), .i_DLCLK_n(dl),
        .o_DHCLK_n(dh1), .o_DLCLK_n(dlo1), .o_PHASE(ph1), .o_LOCKED(lk1),
        .o_IRST(ir1), .o_MISCNT(mc1)
    );

    int n_chk = 0, n_fail = 0, tick_no = 0, last_edge = 0;

    // Reference model state (slave: m_*, master: m0_*)
    logic [1:0] m_ph, m0_ph;
    int         m_st, m_cnt, m_to, m_hold, m_mis, m0_hold;
    logic       m_irst, m_prev, m0_lk, m0_irst;

    function automatic logic [13:0] exp1();
        return {m_ph[1], m_ph[0], m_ph, 1'(m_st == S_LOCK), m_irst, 8'(m_mis)};
    endfunction

    function automatic logic [13:0] exp0();
        return {m0_ph[1], m0_ph[0], m0_ph, m0_lk, m0_irst, 8'h00};
    endfunction

    task automatic model_reset();
        m_ph = 2'b11; m_st = S_SEARCH; m_cnt = 0; m_to = 0; m_hold = 0;
        m_irst = 1'b1; m_mis = 0; m_prev = 1'b1;
        m0_ph = 2'b11; m0_lk = 1'b0; m0_irst = 1'b1; m0_hold = 0;
        tick_no = 0;
    endtask

    // One tick: level lvl is driven right after a tick and is the synchronized level seen at the next tick.
    task automatic step(input logic lvl);
        logic e, lk_pre;
        dl = lvl; ncen = 1'b0;
        repeat (3) @(posedge clk);
        #1 ncen = 1'b1;
        @(posedge clk);
        #1 ncen = 1'b0;
        tick_no++;
        e = m_prev && !lvl;
        m_prev = lvl;
        lk_pre = (m_st == S_LOCK);
        if (m_irst) begin
            if (lk_pre) begin m_hold++; if (m_hold == RST_HOLD) m_irst = 1'b0; end
            else m_hold = 0;
        end
        if (e) begin
            last_edge = tick_no;
            if (m_st == S_SEARCH) begin
                if (m_ph != 2'd3) m_cnt = 0;
                else if (m_cnt == LOCK_EDGES - 1) begin m_st = S_LOCK; m_cnt = 0; end
                else m_cnt++;
            end else if (m_st == S_LOCK) begin
                if (m_ph != 2'd3) begin
                    m_st = S_SEARCH; m_cnt = 0;
`ifdef IKA9958_CLKGEN_MISCNT_EN
                    if (m_mis < 255) m_mis++;
`endif
                end
            end else begin
                m_st = S_SEARCH; m_cnt = 0;
            end
            m_ph = 2'd0; m_to = 0;
        end else begin
            m_ph = m_ph + 2'd1;
            if (m_to < NOCLK_TICKS) m_to++;
            if (m_to == NOCLK_TICKS) m_st = S_NOCLK;
        end
        if (m0_irst) begin
            if (m0_lk) begin m0_hold++; if (m0_hold == RST_HOLD) m0_irst = 1'b0; end
            else m0_hold = 0;
        end
        m0_lk = 1'b1;
        m0_ph = m0_ph + 2'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; dl = 1'b1; ncen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (obs0 !== RST_EXP) begin n_fail++; $display("FAIL reset_master: got %h want %h", obs0, RST_EXP); end
        n_chk++; if (obs1 !== RST_EXP) begin n_fail++; $display("FAIL reset_slave: got %h want %h", obs1, RST_EXP); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_master_and_lock();
        int t_ir0 = -1, t_lk1 = -1, t_ir1 = -1;
        for (int k = 0; k < 24; k++) begin
            step((k % 4) >= 2);
            n_chk++; if (obs0 !== exp0()) begin n_fail++; $display("FAIL master tick %0d: got %h want %h", tick_no, obs0, exp0()); end
            n_chk++; if (obs1 !== exp1()) begin n_fail++; $display("FAIL lock tick %0d: got %h want %h", tick_no, obs1, exp1()); end
            if (t_ir0 < 0 && ir0 === 1'b0) t_ir0 = tick_no;
            if (t_lk1 < 0 && lk1 === 1'b1) t_lk1 = tick_no;
            if (t_ir1 < 0 && ir1 === 1'b0) t_ir1 = tick_no;
        end
        n_chk++; if (t_ir0 != 9)  begin n_fail++; $display("FAIL master_irst_tick: got %0d want 9", t_ir0); end
        n_chk++; if (t_lk1 != 13) begin n_fail++; $display("FAIL slave_lock_tick: got %0d want 13", t_lk1); end
        n_chk++; if (t_ir1 != 21) begin n_fail++; $display("FAIL slave_irst_tick: got %0d want 21", t_ir1); end
        n_chk++; if (mc1 !== 8'h00) begin n_fail++; $display("FAIL lock_miscnt: got %0d want 0", mc1); end
    endtask

    task automatic test_realign();
        for (int k = 0; k < 40; k++) begin
            if (k < 20) step((k % 5) < 3);
            else        step(((k - 20) % 4) < 2);
            n_chk++; if (obs1 !== exp1()) begin n_fail++; $display("FAIL realign tick %0d: got %h want %h", tick_no, obs1, exp1()); end
        end
        n_chk++; if (lk1 !== 1'b1)    begin n_fail++; $display("FAIL relock: got %b want 1", lk1); end
        n_chk++; if (ir1 !== 1'b0)    begin n_fail++; $display("FAIL realign_irst: got %b want 0", ir1); end
        n_chk++; if (mc1 !== MIS_EXP) begin n_fail++; $display("FAIL realign_miscnt: got %0d want %0d", mc1, MIS_EXP); end
    endtask

    task automatic test_noclk();
        int t_drop = -1;
        for (int k = 0; k < 24; k++) begin
            step(1'b1);
            n_chk++; if (obs1 !== exp1()) begin n_fail++; $display("FAIL noclk tick %0d: got %h want %h", tick_no, obs1, exp1()); end
            if (t_drop < 0 && lk1 === 1'b0) t_drop = tick_no;
        end
        n_chk++; if (t_drop - last_edge != NOCLK_TICKS) begin
            n_fail++; $display("FAIL noclk_timeout: got %0d ticks want %0d", t_drop - last_edge, NOCLK_TICKS);
        end
    endtask

    task automatic test_random();
        int hi, lo;
        for (int i = 0; i < 80; i++) begin
            hi = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 4));
            lo = $urandom_range(1, 4);
            for (int j = 0; j < hi + lo; j++) begin
                step(j < hi);
                n_chk++; if (obs1 !== exp1()) begin n_fail++; $display("FAIL random tick %0d: got %h want %h", tick_no, obs1, exp1()); end
                n_chk++; if (obs0 !== exp0()) begin n_fail++; $display("FAIL random_master tick %0d: got %h want %h", tick_no, obs0, exp0()); end
            end
        end
    endtask

    task automatic test_reset_midlock();
        for (int k = 0; k < 40; k++) begin
            step((k % 4) >= 2);
            n_chk++; if (obs1 !== exp1()) begin n_fail++; $display("FAIL prelock tick %0d: got %h want %h", tick_no, obs1, exp1()); end
        end
        n_chk++; if (lk1 !== 1'b1) begin n_fail++; $display("FAIL prelock_locked: got %b want 1", lk1); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (obs1 !== RST_EXP) begin n_fail++; $display("FAIL midlock_reset: got %h want %h", obs1, RST_EXP); end
        n_chk++; if (obs0 !== RST_EXP) begin n_fail++; $display("FAIL midlock_reset_master: got %h want %h", obs0, RST_EXP); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_master_and_lock();
        test_realign();
        test_noclk();
        test_random();
        test_reset_midlock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
